mtr_drv_nch: RTL and testbench
==============================

// Module: mtr_drv_nch
// PURPOSE
//  Parametrised N-channel H-bridge PWM motor driver; successor to the fixed 2-channel 11-bit driver.
//  Converts signed per-channel speed commands to offset-binary duty, with per-channel features:
//  - period-synchronous (glitch-free) duty update
//  - slew-rate limiting, dead-time insertion, coast and brake modes
//  Sits between the motor-control loop and the motor pins.
// PARAMETERS
//  NCH    2   number of motor channels
//  SPD_W  11  speed/duty width; PWM period = 2**SPD_W clocks
//  DEAD   6   dead-time in clocks before either output of a channel may rise (0 = none)
//  SLEW   8   max duty change per PWM period (0 = unlimited)
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            asynchronous active-low reset
//  spd          in   NCH*SPD_W    packed signed speed commands; ch i = spd[i*SPD_W +: SPD_W]
//  en           in   NCH          1 = drive; 0 = coast (both outputs low)
//  brake        in   NCH          1 = jump duty to midpoint at next boundary, bypassing slew
//  pwm1         out  NCH          low-side-phase output (complement of pwm2, dead-timed)
//  pwm2         out  NCH          high-side-phase output
//  period_strt  out  1            one-clock pulse in the cycle the counter is 0
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - cnt=0, every duty=MID (2**(SPD_W-1)), dead counters=0
//   - pwm1=pwm2=0, period_strt=0
//  Counter and boundary
//   - Shared free-running cnt[SPD_W-1:0]; increments every clk; wraps MAX (all-ones) -> 0
//   - Boundary cycle = cnt==MAX; spd, en and brake are sampled only in that cycle
//  Duty update per channel, at the boundary
//   - tgt = spd + MID, modulo 2**SPD_W (offset binary: -MID->0, 0->MID, MID-1->MAX)
//   - priority: en=0 or brake=1 -> duty<=MID; SLEW==0 -> duty<=tgt;
//     |tgt-duty|<=SLEW -> duty<=tgt; else duty<=duty+/-SLEW toward tgt
//   - Compute the difference in SPD_W+1 signed bits; no wrap-around in the step
//   - New duty takes effect from cnt==0; latency = sampling boundary + 1 clk
//   - spd changes mid-period are ignored
//  Raw PWM
//   - raw = (cnt < duty); duty=0 -> never high; duty=MAX -> high 2**SPD_W-1 of 2**SPD_W clocks
//  Dead time per output (pwm2 follows raw, pwm1 follows ~raw)
//   - Falls in the clock after its raw level drops
//   - Rises only after its raw level has been held high for DEAD consecutive clocks
//   - pwm1&pwm2 never 1 together; both are 0 for >=DEAD clocks at each transition
//   - A raw pulse shorter than DEAD clocks is suppressed
//  Outputs
//   - All outputs registered; en=0 (as held in the enable latch from the last boundary)
//     forces pwm1=pwm2=0 and clears the dead counters
//   - period_strt registered, asserted while cnt==0
//  Simultaneous events
//   - en=0 with brake=1: coast wins (outputs low, duty=MID)
//   - brake release: slew resumes from MID
//  Mid-operation reset returns to the reset state immediately; no partial period after release.
// STRUCTURE
//  Package mtr_drv_pkg
//   - function offset_duty(spd) -> duty
//   - function slew_step(duty, tgt, slew) -> next duty
//  Sub-module mtr_pwm_ch (one per channel, generate loop)
//   - inputs: cnt, boundary, spd_i, en_i, brake_i; outputs: pwm1_i, pwm2_i
//   - contains: duty register, enable latch, compare, two dead-time counters ($clog2(DEAD+1) bits)
//  Top owns cnt and period_strt.
// TESTING (NCH=2, SPD_W=11, DEAD=6, SLEW=8 unless noted)
//  1. Reset with spd=0, SLEW=0, en=1 -> pwm2 high 1024-6 clks, pwm1 high 1024-6 clks per 2048-clk
//     period; both low 6 clks at each edge.
//  2. SLEW=8, en=1, step spd 0->+100 -> duty 1024,1032,...,1120,1124; reaches 1124 at the 13th
//     boundary; monotonic.
//  3. spd changed at cnt=500 -> duty unchanged until cnt==0 after next MAX; no glitch on pwm2.
//  4. spd=-1024 (duty 0) -> pwm2 never high; spd=+1023 (duty 2047) -> pwm1 never high (pulse < DEAD).
//  5. brake=1 at duty 1500 -> duty=1024 next period, no ramp; en=0 -> pwm1=pwm2=0 from the period
//     after the boundary; en=0 with brake=1 behaves as coast.
//  6. rst_n low at cnt=700 -> outputs 0 asynchronously; after release cnt restarts at 0,
//     period_strt pulses; assert pwm1&pwm2 is never 1 throughout.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// Shared types and arithmetic helpers for the N-channel H-bridge PWM driver.
//   offset_duty : signed speed command -> offset-binary duty (speed + MID, mod 2**sw)
//   slew_step   : move a duty toward a target by at most 'slew' (0 = jump straight there)
// Helpers work on a fixed MAX_W-bit container; callers zero-extend their
// SPD_W-bit values in and take the low SPD_W bits of the result.
package mtr_drv_pkg;

    localparam int MAX_W = 16;

    typedef logic [MAX_W-1:0] duty_t;

    // Per-channel duty update source chosen at a period boundary.
    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_BRAKE = 2'd1,
        MODE_COAST = 2'd2
    } ch_mode_e;

    function automatic duty_t offset_duty(input duty_t spd, input int sw);
        duty_t mask;
        duty_t mid;
        mask = duty_t'((32'd1 << sw) - 32'd1);
        mid  = duty_t'(32'd1 << (sw - 1));
        return (spd + mid) & mask;
    endfunction

    // The difference is taken one bit wider than the operands so that a large
    // swing never wraps; the step itself cannot overshoot because it is only
    // taken when the target lies further away than 'slew'.
    function automatic duty_t slew_step(input duty_t duty, input duty_t tgt, input int slew);
        logic signed [MAX_W:0] diff;
        logic signed [MAX_W:0] lim;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});
        lim  = $signed({1'b0, duty_t'(slew)});
        if (slew == 0) begin
            return tgt;
        end else if (diff > lim) begin
            return duty + duty_t'(slew);
        end else if (diff < -lim) begin
            return duty - duty_t'(slew);
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mtr_drv_nch_if.sv
// Command/pin bundle between the motor-control loop and the PWM driver.
//   spd         packed signed speed commands, channel i at spd[i*SPD_W +: SPD_W]
//   en          per-channel drive enable (0 = coast)
//   brake       per-channel brake request
//   pwm1/pwm2   low-/high-side phase outputs
//   period_strt one-clock pulse while the shared counter is 0
// There is no valid/ready handshake on this bundle: spd, en and brake are
// level signals that the driver samples only in the last cycle of each PWM
// period; whatever they hold at any other time is ignored.
interface mtr_drv_nch_if #(
    parameter int NCH   = 2,
    parameter int SPD_W = 11
);
    logic [NCH*SPD_W-1:0] spd;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       brake;
    logic [NCH-1:0]       pwm1;
    logic [NCH-1:0]       pwm2;
    logic                 period_strt;

    modport master (
        output spd, en, brake,
        input  pwm1, pwm2, period_strt
    );

    modport slave (
        input  spd, en, brake,
        output pwm1, pwm2, period_strt
    );
endinterface

// File: rtl/mtr_pwm_ch.sv
// One H-bridge channel: duty register, enable latch, PWM compare and two
// dead-time counters.
//   clk, rst_n  clock, asynchronous active-low reset
//   cnt         shared period counter
//   boundary    high in the last cycle of a period (cnt == all-ones)
//   spd_i       signed speed command for this channel
//   en_i        drive enable (0 = coast)
//   brake_i     brake request (duty to midpoint, no slew)
//   pwm1_i      low-side phase output (follows ~raw, dead-timed)
//   pwm2_i      high-side phase output (follows raw, dead-timed)
module mtr_pwm_ch
    import mtr_drv_pkg::*;
#(
    parameter int SPD_W = 11,
    parameter int DEAD  = 6,
    parameter int SLEW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SPD_W-1:0] cnt,
    input  logic             boundary,
    input  logic [SPD_W-1:0] spd_i,
    input  logic             en_i,
    input  logic             brake_i,
    output logic             pwm1_i,
    output logic             pwm2_i
);
    localparam int               DC_W   = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam logic [DC_W-1:0]  DC_MAX = DC_W'(DEAD);
    localparam logic [SPD_W-1:0] MID    = {1'b1, {(SPD_W-1){1'b0}}};

    logic [SPD_W-1:0] duty_q, duty_d;
    logic             en_q, en_d;
    logic [DC_W-1:0]  dc1_q, dc1_d;
    logic [DC_W-1:0]  dc2_q, dc2_d;
    logic             pwm1_q, pwm1_d;
    logic             pwm2_q, pwm2_d;
    ch_mode_e         mode;
    duty_t            tgt_w;
    duty_t            step_w;
    logic             raw;

    always_comb begin
        tgt_w  = offset_duty(duty_t'(spd_i), SPD_W);
        step_w = slew_step(duty_t'(duty_q), tgt_w, SLEW);
        mode   = MODE_RUN;
        duty_d = duty_q;
        en_d   = en_q;
        dc1_d  = '0;
        dc2_d  = '0;

        // Coast outranks brake; both park the duty at the midpoint.
        if (!en_i) begin
            mode = MODE_COAST;
        end else if (brake_i) begin
            mode = MODE_BRAKE;
        end

        if (boundary) begin
            en_d = en_i;
            case (mode)
                MODE_COAST, MODE_BRAKE: duty_d = MID;
                default:                duty_d = step_w[SPD_W-1:0];
            endcase
        end

        raw = (cnt < duty_q);

        // Each counter holds how long its raw level has been high, saturating
        // at DEAD; the output may only be high once that run has reached DEAD
        // and the level is still high.
        if (en_q && raw) begin
            dc2_d = (dc2_q == DC_MAX) ? DC_MAX : dc2_q + DC_W'(1);
        end
        if (en_q && !raw) begin
            dc1_d = (dc1_q == DC_MAX) ? DC_MAX : dc1_q + DC_W'(1);
        end
        pwm2_d = en_q && raw && (dc2_q == DC_MAX);
        pwm1_d = en_q && !raw && (dc1_q == DC_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= MID;
            en_q   <= 1'b0;
            dc1_q  <= '0;
            dc2_q  <= '0;
            pwm1_q <= 1'b0;
            pwm2_q <= 1'b0;
        end else begin
            duty_q <= duty_d;
            en_q   <= en_d;
            dc1_q  <= dc1_d;
            dc2_q  <= dc2_d;
            pwm1_q <= pwm1_d;
            pwm2_q <= pwm2_d;
        end
    end

    assign pwm1_i = pwm1_q;
    assign pwm2_i = pwm2_q;
endmodule

// File: rtl/mtr_drv_nch.sv
// N-channel H-bridge PWM motor driver. Owns the shared free-running period
// counter and the period-start pulse; each channel is an mtr_pwm_ch.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of mtr_drv_nch_if (spd/en/brake in, pwm1/pwm2/period_strt out)
// PWM period is 2**SPD_W clocks. Commands are taken in the last cycle of a
// period and take effect from the following cnt == 0.
module mtr_drv_nch
    import mtr_drv_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int SPD_W = 11,
    parameter int DEAD  = 6,
    parameter int SLEW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mtr_drv_nch_if.slave  bus
);
    localparam logic [SPD_W-1:0] CNT_MAX = '1;

    logic [SPD_W-1:0] cnt_q, cnt_d;
    logic             ps_q, ps_d;
    logic             boundary;
    logic [NCH-1:0]   pwm1_w;
    logic [NCH-1:0]   pwm2_w;

    always_comb begin
        boundary = (cnt_q == CNT_MAX);
        cnt_d    = cnt_q + SPD_W'(1);
        // Registered one cycle ahead so the pulse coincides with cnt == 0.
        ps_d     = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ps_q  <= ps_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mtr_pwm_ch #(
            .SPD_W (SPD_W),
            .DEAD  (DEAD),
            .SLEW  (SLEW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (cnt_q),
            .boundary (boundary),
            .spd_i    (bus.spd[i*SPD_W +: SPD_W]),
            .en_i     (bus.en[i]),
            .brake_i  (bus.brake[i]),
            .pwm1_i   (pwm1_w[i]),
            .pwm2_i   (pwm2_w[i])
        );
    end

    assign bus.pwm1        = pwm1_w;
    assign bus.pwm2        = pwm2_w;
    assign bus.period_strt = ps_q;
endmodule

// File: tb/tb_mtr_drv_nch.sv
// Bench for mtr_drv_nch. Two instances: dut_a with the default parameters
// (SPD_W=11, DEAD=6, SLEW=8) and dut_b with SPD_W=6, DEAD=3, SLEW=0 so that
// full-scale duty and short-pulse suppression are reachable in a few periods.
// A behavioural model (integer run lengths, arithmetic duty update) predicts
// every output every cycle; directed sequences pin the model with literals.
module tb_mtr_drv_nch;

    logic clk;
    logic rst_n;

    logic [10:0] a_spd0, a_spd1;
    logic        a_en0, a_en1, a_brk0, a_brk1;
    logic [5:0]  b_spd0, b_spd1;
    logic        b_en0, b_en1, b_brk0, b_brk1;

    int n_chk;
    int n_pass;
    bit done;
    bit log_on;
    int duty_log[$];

    // Model state, index [dut][channel]
    int   m_cnt  [2];
    int   m_duty [2][2];
    logic m_en   [2][2];
    int   m_r1   [2][2];
    int   m_r2   [2][2];
    logic m_p1   [2][2];
    logic m_p2   [2][2];
    logic m_ps   [2];

    mtr_drv_nch_if #(.NCH(2), .SPD_W(11)) bus_a ();
    mtr_drv_nch_if #(.NCH(2), .SPD_W(6))  bus_b ();

    assign bus_a.spd   = {a_spd1, a_spd0};
    assign bus_a.en    = {a_en1, a_en0};
    assign bus_a.brake = {a_brk1, a_brk0};
    assign bus_b.spd   = {b_spd1, b_spd0};
    assign bus_b.en    = {b_en1, b_en0};
    assign bus_b.brake = {b_brk1, b_brk0};

    mtr_drv_nch #(.NCH(2), .SPD_W(11), .DEAD(6), .SLEW(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mtr_drv_nch #(.NCH(2), .SPD_W(6), .DEAD(3), .SLEW(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    function automatic int sw_of(input int d);
        return (d == 0) ? 11 : 6;
    endfunction

    function automatic int dead_of(input int d);
        return (d == 0) ? 6 : 3;
    endfunction

    function automatic int slew_of(input int d);
        return (d == 0) ? 8 : 0;
    endfunction

    function automatic logic ps_of(input int d);
        return (d == 0) ? bus_a.period_strt : bus_b.period_strt;
    endfunction

    function automatic logic pin(input int d, input int ch, input int which);
        if (d == 0) return (which == 1) ? bus_a.pwm1[ch] : bus_a.pwm2[ch];
        return (which == 1) ? bus_b.pwm1[ch] : bus_b.pwm2[ch];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            m_ps[d]  = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_duty[d][c] = (1 << sw_of(d)) / 2;
                m_en[d][c]   = 1'b0;
                m_r1[d][c]   = 0;
                m_r2[d][c]   = 0;
                m_p1[d][c]   = 1'b0;
                m_p2[d][c]   = 1'b0;
            end
        end
    endtask

    // One clock of one instance. Outputs are high only when the matching raw
    // level is high now and was already high for at least DEAD clocks before.
    task automatic model_step(input int d, input int s0, input int s1,
                              input logic [1:0] en, input logic [1:0] brk);
        int   n, mid, dead, slew, spd, tgt, diff;
        logic raw;
        n    = 1 << sw_of(d);
        mid  = n / 2;
        dead = dead_of(d);
        slew = slew_of(d);
        for (int c = 0; c < 2; c++) begin
            raw = (m_cnt[d] < m_duty[d][c]);
            m_p2[d][c] = m_en[d][c] && raw && (m_r2[d][c] >= dead);
            m_p1[d][c] = m_en[d][c] && !raw && (m_r1[d][c] >= dead);
            m_r2[d][c] = (m_en[d][c] && raw) ? m_r2[d][c] + 1 : 0;
            m_r1[d][c] = (m_en[d][c] && !raw) ? m_r1[d][c] + 1 : 0;
            if (m_cnt[d] == n - 1) begin
                spd = (c == 0) ? s0 : s1;
                tgt = (spd + mid + n) % n;
                if (!en[c] || brk[c]) begin
                    m_duty[d][c] = mid;
                end else begin
                    diff = tgt - m_duty[d][c];
                    if (slew == 0 || (diff <= slew && diff >= -slew)) m_duty[d][c] = tgt;
                    else if (diff > 0) m_duty[d][c] = m_duty[d][c] + slew;
                    else m_duty[d][c] = m_duty[d][c] - slew;
                end
                m_en[d][c] = en[c];
            end
        end
        m_ps[d]  = (m_cnt[d] == n - 1);
        m_cnt[d] = (m_cnt[d] + 1) % n;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, int'($signed(a_spd0)), int'($signed(a_spd1)), bus_a.en, bus_a.brake);
            model_step(1, int'($signed(b_spd0)), int'($signed(b_spd1)), bus_b.en, bus_b.brake);
            if (log_on && m_ps[0]) duty_log.push_back(m_duty[0][0]);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!done) begin
            check("a_pwm1", int'(bus_a.pwm1), int'({m_p1[0][1], m_p1[0][0]}));
            check("a_pwm2", int'(bus_a.pwm2), int'({m_p2[0][1], m_p2[0][0]}));
            check("a_period_strt", int'(bus_a.period_strt), int'(m_ps[0]));
            check("a_overlap", int'(bus_a.pwm1 & bus_a.pwm2), 0);
            check("b_pwm1", int'(bus_b.pwm1), int'({m_p1[1][1], m_p1[1][0]}));
            check("b_pwm2", int'(bus_b.pwm2), int'({m_p2[1][1], m_p2[1][0]}));
            check("b_period_strt", int'(bus_b.period_strt), int'(m_ps[1]));
            check("b_overlap", int'(bus_b.pwm1 & bus_b.pwm2), 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Step to the cycle in which the instance shows cnt == 0 (bounded).
    task automatic align(input int d);
        int k;
        int lim;
        k   = 0;
        lim = (1 << sw_of(d)) + 4;
        do begin
            @(negedge clk);
            k++;
        end while (!ps_of(d) && k < lim);
        check((d == 0) ? "align_a" : "align_b", int'(ps_of(d)), 1);
    endtask

    task automatic count_hi(input int d, input int ch, input int which,
                            input int ncyc, output int hi);
        hi = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (pin(d, ch, which)) hi++;
        end
    endtask

    // Random background traffic: dut_a channel 1 and dut_b channel 0,
    // changed at arbitrary points inside the period.
    initial begin
        a_spd1 = '0; a_en1 = 1'b1; a_brk1 = 1'b0;
        b_spd0 = '0; b_en0 = 1'b1; b_brk0 = 1'b0;
        while (!done) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            a_spd1 = 11'($urandom_range(0, 2047));
            a_en1  = ($urandom_range(0, 9) != 0);
            a_brk1 = ($urandom_range(0, 9) == 0);
            b_spd0 = 6'($urandom_range(0, 63));
            b_en0  = ($urandom_range(0, 5) != 0);
            b_brk0 = ($urandom_range(0, 7) == 0);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int hi;
        int first_a;
        int first_b;
        int exp_d;

        n_chk  = 0;
        n_pass = 0;
        done   = 1'b0;
        log_on = 1'b0;
        rst_n  = 1'b1;
        a_spd0 = '0;  a_en0 = 1'b1; a_brk0 = 1'b0;
        b_spd1 = 6'b100000; b_en1 = 1'b1; b_brk1 = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_a_pwm1", int'(bus_a.pwm1), 0);
        check("rst_a_pwm2", int'(bus_a.pwm2), 0);
        check("rst_a_ps", int'(bus_a.period_strt), 0);
        check("rst_b_pwm", int'(bus_b.pwm1 | bus_b.pwm2), 0);
        check("rst_model_duty_a", m_duty[0][0], 1024);
        check("rst_model_duty_b", m_duty[1][1], 32);
        rst_n = 1'b1;

        // Midpoint duty: each phase high 1024-6 clocks per period
        align(0);
        align(0);
        count_hi(0, 0, 2, 2048, hi);
        check("t1_pwm2_high", hi, 1018);
        count_hi(0, 0, 1, 2048, hi);
        check("t1_pwm1_high", hi, 1018);

        // Full-scale duty on dut_b channel 1
        align(1);
        count_hi(1, 1, 2, 64, hi);
        check("t4_duty0_pwm2", hi, 0);
        count_hi(1, 1, 1, 64, hi);
        check("t4_duty0_pwm1", hi, 64);
        b_spd1 = 6'd31;
        align(1);
        align(1);
        count_hi(1, 1, 1, 64, hi);
        check("t4_dutymax_pwm1", hi, 0);
        count_hi(1, 1, 2, 64, hi);
        check("t4_dutymax_pwm2", hi, 60);

        // Slew ramp 0 -> +100
        align(0);
        duty_log.delete();
        log_on = 1'b1;
        a_spd0 = 11'd100;
        repeat (14) align(0);
        log_on = 1'b0;
        check("t2_log_len", duty_log.size(), 14);
        for (int k = 0; k < duty_log.size(); k++) begin
            exp_d = 1024 + 8 * (k + 1);
            if (exp_d > 1124) exp_d = 1124;
            check("t2_ramp_duty", duty_log[k], exp_d);
        end
        count_hi(0, 0, 2, 2048, hi);
        check("t2_pwm2_high_1124", hi, 1118);

        // Brake, release, coast, coast+brake
        a_brk0 = 1'b1;
        align(0);
        check("t5_brake_duty", m_duty[0][0], 1024);
        count_hi(0, 0, 2, 2048, hi);
        check("t5_brake_pwm2_high", hi, 1018);
        a_brk0 = 1'b0;
        align(0);
        check("t5_release_duty", m_duty[0][0], 1032);
        a_en0 = 1'b0;
        align(0);
        check("t5_coast_duty", m_duty[0][0], 1024);
        count_hi(0, 0, 2, 2048, hi);
        check("t5_coast_pwm2", hi, 0);
        a_brk0 = 1'b1;
        align(0);
        count_hi(0, 0, 1, 2048, hi);
        check("t5_coast_brake_pwm1", hi, 0);
        check("t5_coast_brake_duty", m_duty[0][0], 1024);
        a_en0  = 1'b1;
        a_brk0 = 1'b0;

        // Asynchronous reset mid-period
        align(0);
        repeat (700) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_a_pwm", int'(bus_a.pwm1 | bus_a.pwm2), 0);
        check("t6_async_b_pwm", int'(bus_b.pwm1 | bus_b.pwm2), 0);
        check("t6_async_ps", int'(bus_a.period_strt | bus_b.period_strt), 0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        first_a = -1;
        first_b = -1;
        for (int k = 1; k <= 2100; k++) begin
            @(negedge clk);
            if (first_a < 0 && bus_a.period_strt) first_a = k;
            if (first_b < 0 && bus_b.period_strt) first_b = k;
        end
        check("t6_restart_a", first_a, 2048);
        check("t6_restart_b", first_b, 64);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
